// File: rtl/lenet_pkg.sv
// Shared LeNet definitions: conv2 geometry, scheduler state encoding and a
// constant-function clog2 usable in parameter expressions.
package lenet_pkg;

    localparam int CONV2_OUT_DIM   = 10;
    localparam int CONV2_MAP_WORDS = CONV2_OUT_DIM * CONV2_OUT_DIM;
    localparam int F4_BASE_W       = 11;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_LAUNCH = 6'b000010,
        ST_WAIT   = 6'b000100,
        ST_GAP    = 6'b001000,
        ST_FINISH = 6'b010000,
        ST_ERR    = 6'b100000
    } sched_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv2_oc_sched_if.sv
// Handshake bundle between the layer sequencer / conv2 controller side (master)
// and the output-channel pass scheduler (slave).
interface conv2_oc_sched_if
    import lenet_pkg::*;
#(
    parameter int GRP_W = 2
) ();
    logic                 layer_start;
    logic                 abort;
    logic                 conv2_done;
    logic                 conv2_start;
    logic [GRP_W-1:0]     oc_grp;
    logic [GRP_W-1:0]     w3_bank;
    logic [F4_BASE_W-1:0] f4_base;
    logic                 busy;
    logic                 layer_done;
    logic                 err_timeout;
    logic                 err_unexp;

    modport master (
        output layer_start, abort, conv2_done,
        input  conv2_start, oc_grp, w3_bank, f4_base, busy, layer_done,
               err_timeout, err_unexp
    );

    modport slave (
        input  layer_start, abort, conv2_done,
        output conv2_start, oc_grp, w3_bank, f4_base, busy, layer_done,
               err_timeout, err_unexp
    );
endinterface

// File: rtl/conv2_oc_sched_timer.sv
// Loadable saturating down-counter; one instance times both the inter-pass gap
// and the WAIT timeout since the two are never active together.
module sched_timer #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)                   cnt_d = load_val;
        else if (dec && cnt_q != 0) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/conv2_oc_sched.sv
// Output-channel pass scheduler for conv2: launches NUM_OC/PAR_OC passes and
// holds the group index, weight bank and f4 write base stable across each pass.
module conv2_oc_sched
    import lenet_pkg::*;
#(
    parameter int NUM_OC  = 16,
    parameter int PAR_OC  = 4,
    parameter int F4_MAP  = CONV2_MAP_WORDS,
    parameter int GAP_CYC = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    conv2_oc_sched_if.slave   bus
);
    localparam int NGRP       = NUM_OC / PAR_OC;
    localparam int GRP_W      = (clog2(NGRP) < 1) ? 1 : clog2(NGRP);
    localparam int CNT_W      = clog2((TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC);
    localparam int PASS_WORDS = PAR_OC * F4_MAP;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGRP - 1);

    if (NUM_OC % PAR_OC != 0) begin : g_bad_par
        $error("conv2_oc_sched: NUM_OC must be a multiple of PAR_OC");
    end
    if (NUM_OC * F4_MAP > 2048) begin : g_bad_f4
        $error("conv2_oc_sched: f4 output does not fit the 11-bit base");
    end
    if (GAP_CYC < 1 || TIMEOUT < 16) begin : g_bad_tim
        $error("conv2_oc_sched: GAP_CYC must be >=1 and TIMEOUT >=16");
    end

    sched_state_e         state_q, state_d;
    logic [GRP_W-1:0]     oc_grp_q, oc_grp_d;
    logic [F4_BASE_W-1:0] f4_base_q, f4_base_d;
    logic                 conv2_start_q, conv2_start_d;
    logic                 busy_q, busy_d;
    logic                 layer_done_q, layer_done_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 err_unexp_q, err_unexp_d;

    logic             start_ok, grp_inc;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    sched_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        grp_inc  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.layer_start) begin
                        state_d  = ST_LAUNCH;
                        start_ok = 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    state_d  = ST_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(TIMEOUT - 1);
                end
                ST_WAIT: begin
                    // done is checked before the timeout so a coincident done still counts
                    if (bus.conv2_done) begin
                        if (oc_grp_q == LAST_GRP) begin
                            state_d = ST_FINISH;
                        end else begin
                            state_d  = ST_GAP;
                            tmr_load = 1'b1;
                            tmr_val  = CNT_W'(GAP_CYC - 1);
                        end
                    end else if (tmr_zero) begin
                        state_d = ST_ERR;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        state_d = ST_LAUNCH;
                        grp_inc = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_FINISH: state_d = ST_IDLE;
                ST_ERR:    state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are derived from the next state so every output is a flop.
    always_comb begin
        oc_grp_d = oc_grp_q;
        if (start_ok)     oc_grp_d = '0;
        else if (grp_inc) oc_grp_d = oc_grp_q + 1'b1;

        f4_base_d     = F4_BASE_W'(int'(oc_grp_d) * PASS_WORDS);
        conv2_start_d = (state_d == ST_LAUNCH);
        busy_d        = (state_d == ST_LAUNCH) || (state_d == ST_WAIT) || (state_d == ST_GAP);
        layer_done_d  = (state_d == ST_FINISH);

        err_timeout_d = err_timeout_q;
        if (start_ok)               err_timeout_d = 1'b0;
        else if (state_d == ST_ERR) err_timeout_d = 1'b1;

        err_unexp_d = err_unexp_q;
        if (start_ok) err_unexp_d = 1'b0;
        if (!bus.abort && bus.conv2_done && state_q != ST_WAIT) err_unexp_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            oc_grp_q      <= '0;
            f4_base_q     <= '0;
            conv2_start_q <= 1'b0;
            busy_q        <= 1'b0;
            layer_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_unexp_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            oc_grp_q      <= oc_grp_d;
            f4_base_q     <= f4_base_d;
            conv2_start_q <= conv2_start_d;
            busy_q        <= busy_d;
            layer_done_q  <= layer_done_d;
            err_timeout_q <= err_timeout_d;
            err_unexp_q   <= err_unexp_d;
        end
    end

    assign bus.conv2_start = conv2_start_q;
    assign bus.oc_grp      = oc_grp_q;
    assign bus.w3_bank     = oc_grp_q;
    assign bus.f4_base     = f4_base_q;
    assign bus.busy        = busy_q;
    assign bus.layer_done  = layer_done_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_unexp   = err_unexp_q;
endmodule
